// File: rtl/trial_divider_pkg.sv
// Shared constants and state encoding for the trial-division factor engine.
package trial_divider_pkg;

    localparam int WIDTH   = 8;
    localparam int MIN_DIV = 2;
    localparam int MAX_DIV = 19;
    localparam int NUM_DIV = MAX_DIV - MIN_DIV + 1;
    localparam int REM_W   = $clog2(2 * MAX_DIV);
    localparam int DIV_W   = $clog2(MAX_DIV + 1);
    localparam int CNT_W   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DIVIDE = 2'd2,
        RECORD = 2'd3
    } state_t;

endpackage : trial_divider_pkg

// File: rtl/trial_divider_restoring_div_step.sv
// One bit-serial restoring division step: shift in a dividend bit and
// subtract the divisor if it fits.
module restoring_div_step
    import trial_divider_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic             in_bit,
    input  logic [DIV_W-1:0] div,
    output logic [REM_W-1:0] rem_next
);

    logic [REM_W:0] t;
    logic [REM_W:0] div_ext;
    logic [REM_W:0] diff;

    always_comb begin
        t       = {rem, in_bit};
        div_ext = {{(REM_W + 1 - DIV_W){1'b0}}, div};
        diff    = t - div_ext;
        // rem < div keeps the result below div, so it always fits REM_W bits
        if (t >= div_ext) begin
            rem_next = diff[REM_W-1:0];
        end else begin
            rem_next = t[REM_W-1:0];
        end
    end

endmodule : restoring_div_step

// File: rtl/trial_divider.sv
// Sequential factor engine: tests one number against every divisor in
// MIN_DIV..MAX_DIV using a single shared restoring-division datapath.
module trial_divider
    import trial_divider_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   number,
    output logic [NUM_DIV-1:0] factors,
    output logic               valid,
    output logic               busy
);

    state_t             state_q;
    logic [WIDTH-1:0]   latched_q;
    logic               start_pending_q;
    logic [NUM_DIV-1:0] acc_q;
    logic [NUM_DIV-1:0] acc_d;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_idx;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   rem_d;
    logic [WIDTH-1:0]   q_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_DIV-1:0] factors_q;
    logic               valid_q;
    logic               busy_q;
    logic               start;

    restoring_div_step u_step (
        .rem      (rem_q),
        .in_bit   (q_q[WIDTH-1]),
        .div      (div_q),
        .rem_next (rem_d)
    );

    assign start   = (number != latched_q) || start_pending_q;
    assign div_idx = div_q - DIV_W'(MIN_DIV);

    always_comb begin
        acc_d = acc_q;
        if (rem_q == '0) begin
            acc_d[div_idx] = 1'b1;
        end
    end

    // Start is checked ahead of the state actions so a changed number aborts
    // the running computation, including a commit due on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            latched_q       <= '0;
            start_pending_q <= 1'b1;
            acc_q           <= '0;
            div_q           <= DIV_W'(MIN_DIV);
            rem_q           <= '0;
            q_q             <= '0;
            cnt_q           <= '0;
            factors_q       <= '0;
            valid_q         <= 1'b0;
            busy_q          <= 1'b0;
        end else if (start) begin
            latched_q       <= number;
            start_pending_q <= 1'b0;
            acc_q           <= '0;
            div_q           <= DIV_W'(MIN_DIV);
            busy_q          <= 1'b1;
            valid_q         <= 1'b0;
            state_q         <= LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                LOAD: begin
                    rem_q   <= '0;
                    q_q     <= latched_q;
                    cnt_q   <= CNT_W'(WIDTH);
                    state_q <= DIVIDE;
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    q_q   <= q_q << 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RECORD;
                    end
                end
                RECORD: begin
                    acc_q <= acc_d;
                    if (div_q == DIV_W'(MAX_DIV)) begin
                        factors_q <= acc_d;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        div_q   <= div_q + 1'b1;
                        state_q <= LOAD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign factors = factors_q;
    assign valid   = valid_q;
    assign busy    = busy_q;

endmodule : trial_divider
